// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch flush,
// data-memory freeze and a watchdog that traps a memory that never acknowledges.
module pipeline_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       ifid_rs_i,
    input  logic [4:0]       ifid_rt_i,
    input  logic             idex_memread_i,
    input  logic [4:0]       idex_rt_i,
    input  logic             branch_taken_i,
    input  logic             exmem_memread_i,
    input  logic             exmem_memwrite_i,
    input  logic             dmem_ack_i,
    output logic             dmem_req_o,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_write_o,
    output logic             idex_bubble_o,
    output logic             exmem_write_o,
    output logic             memwb_bubble_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [WAIT_W-1:0] wait_q;
    logic [WAIT_W-1:0] wait_d;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic              timeout_q;

    logic memop_c;
    logic load_use_hit_c;
    logic mem_stall_c;
    logic lu_stall_c;
    logic error_c;

    assign memop_c        = exmem_memread_i | exmem_memwrite_i;
    assign load_use_hit_c = idex_memread_i && (idex_rt_i != 5'd0) &&
                            ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));

    // State, wait-state and stall counters
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_RUN;
            wait_q      <= '0;
            stall_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if ((mem_stall_c || lu_stall_c) && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (state_d == ST_ERROR) begin
                timeout_q <= 1'b1;
            end
        end
    end

    // Next state and pipeline controls; priority error > mem stall > load-use > branch
    always_comb begin
        state_d        = state_q;
        wait_d         = wait_q;
        mem_stall_c    = 1'b0;
        lu_stall_c     = 1'b0;
        error_c        = 1'b0;
        dmem_req_o     = 1'b0;
        pc_write_o     = 1'b1;
        ifid_write_o   = 1'b1;
        ifid_flush_o   = 1'b0;
        idex_write_o   = 1'b1;
        idex_bubble_o  = 1'b0;
        exmem_write_o  = 1'b1;
        memwb_bubble_o = 1'b0;

        case (state_q)
            ST_RUN: begin
                dmem_req_o = memop_c;
                if (memop_c && !dmem_ack_i) begin
                    mem_stall_c = 1'b1;
                    state_d     = ST_MEM_WAIT;
                    wait_d      = '0;
                end
            end
            ST_MEM_WAIT: begin
                dmem_req_o = 1'b1;
                if (dmem_ack_i) begin
                    state_d = ST_RUN;
                end else begin
                    mem_stall_c = 1'b1;
                    if (wait_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
                        state_d = ST_ERROR;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end
            end
            ST_ERROR: begin
                error_c = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
                wait_d  = '0;
            end
        endcase

        if (error_c) begin
            dmem_req_o    = 1'b0;
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_write_o  = 1'b0;
            exmem_write_o = 1'b0;
        end else if (mem_stall_c) begin
            pc_write_o     = 1'b0;
            ifid_write_o   = 1'b0;
            idex_write_o   = 1'b0;
            exmem_write_o  = 1'b0;
            memwb_bubble_o = 1'b1;
        end else if (load_use_hit_c) begin
            // Single bubble: next cycle the load has moved on to MEM
            lu_stall_c    = 1'b1;
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_bubble_o = 1'b1;
        end else if (branch_taken_i) begin
            ifid_flush_o = 1'b1;
            pc_write_o   = 1'b1;
        end

        // Whole pipe held while reset is asserted; request dropped at once
        if (rst_i) begin
            dmem_req_o     = 1'b0;
            pc_write_o     = 1'b0;
            ifid_write_o   = 1'b0;
            ifid_flush_o   = 1'b0;
            idex_write_o   = 1'b0;
            idex_bubble_o  = 1'b0;
            exmem_write_o  = 1'b0;
            memwb_bubble_o = 1'b0;
        end
    end

    assign timeout_o   = timeout_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule
